// File: rtl/conv_pass_sched_if.sv
// Handshake and bus bundle between the convolution pass scheduler and its
//   layer controller / engine: layer command (start, num_grp, num_och), weight
//   load handshake (wt_req/wt_ack/wt_och/wt_grp), pixel stream (pix_en/pix_addr),
//   accumulator framing (accu_first/accu_last), line-buffer clear (conv_rst) and
//   status (busy, done). abort exists only when SCHED_ABORT_EN is defined.
// master = scheduler side, slave = controller/engine side.
interface conv_pass_sched_if #(
  parameter int GRP_W = 4
);
  logic             start;
  logic [GRP_W-1:0] num_grp;
  logic [7:0]       num_och;
  logic             wt_req;
  logic             wt_ack;
  logic [7:0]       wt_och;
  logic [GRP_W-1:0] wt_grp;
  logic             pix_en;
  logic [15:0]      pix_addr;
  logic             accu_first;
  logic             accu_last;
  logic             conv_rst;
  logic             busy;
  logic             done;
`ifdef SCHED_ABORT_EN
  logic             abort;

  modport master (
    input  start, num_grp, num_och, wt_ack, abort,
    output wt_req, wt_och, wt_grp, pix_en, pix_addr,
           accu_first, accu_last, conv_rst, busy, done
  );

  modport slave (
    output start, num_grp, num_och, wt_ack, abort,
    input  wt_req, wt_och, wt_grp, pix_en, pix_addr,
           accu_first, accu_last, conv_rst, busy, done
  );
`else
  modport master (
    input  start, num_grp, num_och, wt_ack,
    output wt_req, wt_och, wt_grp, pix_en, pix_addr,
           accu_first, accu_last, conv_rst, busy, done
  );

  modport slave (
    output start, num_grp, num_och, wt_ack,
    input  wt_req, wt_och, wt_grp, pix_en, pix_addr,
           accu_first, accu_last, conv_rst, busy, done
  );
`endif
endinterface

// File: rtl/conv_pass_sched.sv
// Purpose : sequences convolution passes over (och, grp): clear line buffers,
//           load weights, stream IMG_W*IMG_H pixel addresses, drain the engine.
// Latency : per pass 1 (CLR) + load wait + IMG_W*IMG_H + PIPE_LAT + 1 (NEXT);
//           done is a one-cycle pulse in the cycle after the final NEXT.
// Backpressure: only the weight load stalls (wt_req held until wt_ack); the
//           pixel stream never stalls.
// Ports   : clk, rst (async, active-high); bus = conv_pass_sched_if.master
//           carrying start/num_grp/num_och in, wt_ack in, wt_req/wt_och/wt_grp,
//           pix_en/pix_addr, accu_first/accu_last, conv_rst, busy, done out.
// Config  : SCHED_ABORT_EN adds bus.abort, which returns any busy state to
//           IDLE with a done pulse. PIPE_LAT must be >= 1.
module conv_pass_sched #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int PIPE_LAT = 6,
  parameter int GRP_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  conv_pass_sched_if.master bus
);

  localparam logic [15:0] LAST_ADDR = 16'(IMG_W * IMG_H - 1);
  localparam int          DW        = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_NEXT
  } state_t;

  state_t           r_state;
  logic [GRP_W-1:0] r_num_grp;
  logic [7:0]       r_num_och;
  logic [7:0]       r_och;
  logic [GRP_W-1:0] r_grp;
  logic [DW-1:0]    r_drain;
  logic [15:0]      r_pix_addr;
  logic             r_wt_req;
  logic             r_pix_en;
  logic             r_first;
  logic             r_last;
  logic             r_conv_rst;
  logic             r_busy;
  logic             r_done;

  logic [GRP_W-1:0] w_grp_max;
  logic             w_last_grp;
  logic             w_last_och;
  logic             w_layer_end;
  logic [GRP_W-1:0] w_nxt_grp;
  logic [7:0]       w_nxt_och;

  assign w_grp_max   = r_num_grp - GRP_W'(1);
  assign w_last_grp  = (r_grp == w_grp_max);
  assign w_last_och  = (r_och == r_num_och - 8'd1);
  assign w_layer_end = w_last_grp && w_last_och;
  assign w_nxt_grp   = w_last_grp ? '0 : r_grp + GRP_W'(1);
  // och saturates at 255 rather than wrapping.
  assign w_nxt_och   = (w_last_grp && (r_och != 8'hFF)) ? r_och + 8'd1 : r_och;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_num_grp  <= '0;
      r_num_och  <= '0;
      r_och      <= '0;
      r_grp      <= '0;
      r_drain    <= '0;
      r_pix_addr <= '0;
      r_wt_req   <= 1'b0;
      r_pix_en   <= 1'b0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_conv_rst <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // Pulse outputs default low; set only on the transition that owns them.
      r_done     <= 1'b0;
      r_conv_rst <= 1'b0;
`ifdef SCHED_ABORT_EN
      if (bus.abort && (r_state != S_IDLE)) begin
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_wt_req   <= 1'b0;
        r_pix_en   <= 1'b0;
        r_first    <= 1'b0;
        r_last     <= 1'b0;
        r_och      <= '0;
        r_grp      <= '0;
        r_pix_addr <= '0;
        r_done     <= 1'b1;
      end else
`endif
      begin
        unique case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              if ((bus.num_grp == '0) || (bus.num_och == '0)) begin
                // Empty layer: acknowledge with done, never leave IDLE.
                r_done <= 1'b1;
              end else begin
                r_num_grp  <= bus.num_grp;
                r_num_och  <= bus.num_och;
                r_och      <= '0;
                r_grp      <= '0;
                r_first    <= 1'b1;
                r_last     <= (bus.num_grp == GRP_W'(1));
                r_conv_rst <= 1'b1;
                r_busy     <= 1'b1;
                r_state    <= S_CLR;
              end
            end
          end
          S_CLR: begin
            r_wt_req <= 1'b1;
            r_state  <= S_LOAD;
          end
          S_LOAD: begin
            if (bus.wt_ack) begin
              r_wt_req   <= 1'b0;
              r_pix_en   <= 1'b1;
              r_pix_addr <= '0;
              r_state    <= S_STREAM;
            end
          end
          S_STREAM: begin
            // Address holds at the last pixel; it never wraps to 0.
            if (r_pix_addr == LAST_ADDR) begin
              r_pix_en <= 1'b0;
              r_drain  <= DW'(PIPE_LAT - 1);
              r_state  <= S_DRAIN;
            end else begin
              r_pix_addr <= r_pix_addr + 16'd1;
            end
          end
          S_DRAIN: begin
            if (r_drain == '0) begin
              r_state <= S_NEXT;
            end else begin
              r_drain <= r_drain - DW'(1);
            end
          end
          S_NEXT: begin
            if (w_layer_end) begin
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
              r_first    <= 1'b0;
              r_last     <= 1'b0;
              r_och      <= '0;
              r_grp      <= '0;
              r_pix_addr <= '0;
              r_done     <= 1'b1;
            end else begin
              // Framing flags for the coming pass are computed from the
              // next group so they are already valid during its CLR cycle.
              r_grp      <= w_nxt_grp;
              r_och      <= w_nxt_och;
              r_first    <= (w_nxt_grp == '0);
              r_last     <= (w_nxt_grp == w_grp_max);
              r_conv_rst <= 1'b1;
              r_state    <= S_CLR;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.wt_req     = r_wt_req;
  assign bus.wt_och     = r_och;
  assign bus.wt_grp     = r_grp;
  assign bus.pix_en     = r_pix_en;
  assign bus.pix_addr   = r_pix_addr;
  assign bus.accu_first = r_first;
  assign bus.accu_last  = r_last;
  assign bus.conv_rst   = r_conv_rst;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: doc/conv_pass_sched.md
CONV_PASS_SCHED -- requirements
Module: conv_pass_sched

Interface
Parameters (name, default, meaning):
REQ-001 IMG_W, 28: feature-map width in pixels.
REQ-002 IMG_H, 28: feature-map height in pixels.
REQ-003 PIPE_LAT, 6: engine drain cycles after the last pixel of a pass.
REQ-004 GRP_W, 4: width of the group-count field; the maximum is 2^GRP_W-1 input-channel groups of 4.

Ports (name, direction, width, meaning):
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 start  in  1  single-cycle layer start pulse; sampled only in IDLE.
REQ-008 num_grp  in  GRP_W  input-channel groups per output channel (Cin/4).
REQ-009 num_och  in  8  number of output channels.
REQ-010 wt_req  out  1  weight-load request for the current (och, grp).
REQ-011 wt_ack  in  1  weights are loaded into the engine; ignored unless wt_req=1.
REQ-012 wt_och  out  8  current output-channel index.
REQ-013 wt_grp  out  GRP_W  current group index.
REQ-014 pix_en  out  1  pixel-read strobe and engine valid_in.
REQ-015 pix_addr  out  16  row-major pixel address, range 0..IMG_W*IMG_H-1.
REQ-016 accu_first  out  1  high for the whole pass when grp==0 (engine clears its accumulator).
REQ-017 accu_last  out  1  high for the whole pass when grp==num_grp-1 (result to quant/relu/pool).
REQ-018 conv_rst  out  1  one-cycle clear pulse to the line buffers before each pass.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse after the final pass drains.

Function
REQ-021 The FSM states SHALL be IDLE, CLR, LOAD, STREAM, DRAIN, NEXT.
REQ-022 IDLE->CLR on start=1, latching num_grp/num_och; och=0, grp=0.
REQ-023 If start arrives with num_grp=0 or num_och=0, the block SHALL stay in IDLE and pulse done in the next cycle.
REQ-024 CLR: conv_rst=1 for exactly one cycle, then LOAD.
REQ-025 LOAD: wt_req=1 and wt_och/wt_grp are stable until wt_ack; the cycle after wt_ack, the FSM enters STREAM.
REQ-026 STREAM: pix_en=1 on IMG_W*IMG_H consecutive cycles, with pix_addr incrementing by 1 from 0; after the last address, enter DRAIN.
REQ-027 DRAIN: a PIPE_LAT-cycle countdown with pix_en=0, then NEXT.
REQ-028 NEXT (one cycle): if grp<num_grp-1 then grp++, else grp=0 and och++. If och wrapped past num_och-1, go to IDLE with a done pulse; otherwise go to CLR.
REQ-029 accu_first and accu_last SHALL be registered and valid from CLR through DRAIN of each pass; both are high when num_grp=1.
REQ-030 Counters SHALL not wrap: pix_addr stops at IMG_W*IMG_H-1 and och stops at 255.
REQ-031 A start pulse while busy=1 SHALL be ignored.
REQ-032 A wt_ack arriving outside LOAD SHALL be ignored.
REQ-033 All outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-034 On rst=1 all state SHALL clear asynchronously: FSM=IDLE, all counters 0, and every output 0 (including conv_rst, done, busy).
REQ-035 When rst asserts mid-pass, the block SHALL abandon the layer with no done pulse and SHALL restart only on a new start after release.

Configuration
REQ-036 Macro SCHED_ABORT_EN. When defined, input abort (1 bit) SHALL exist; abort=1 in any non-IDLE state forces IDLE the next cycle, with pix_en and wt_req low and a done pulse.
REQ-037 When SCHED_ABORT_EN is undefined, no abort port SHALL exist and only rst terminates a layer.

Verification
REQ-038 IMG_W=IMG_H=4, PIPE_LAT=6, num_grp=2, num_och=2, wt_ack 1 cycle after each wt_req -> 4 passes, 16 pix_en each, order (0,0),(0,1),(1,0),(1,1), accu_first on grp0, accu_last on grp1, a single done.
REQ-039 num_grp=1, num_och=1 -> accu_first=accu_last=1 for the single pass; done arrives 16+6+fixed overhead cycles after wt_ack.
REQ-040 wt_ack delayed 10 cycles -> wt_req held with stable wt_och/wt_grp and pix_en=0 throughout; a stray wt_ack during STREAM changes nothing.
REQ-041 start with num_och=0 -> busy stays 0, done pulses once, no wt_req.
REQ-042 rst asserted on the 7th pix_en of pass 2 -> all outputs 0 immediately, no done; a new start then runs the full sequence from (0,0).
REQ-043 With SCHED_ABORT_EN, abort during DRAIN -> IDLE next cycle and one done pulse; a start during busy is ignored in every run.
